// File: rtl/video_fb_writer_if.sv
// Pixel stream in, Avalon-MM write bus out, bundled so the writer and its
// environment share one set of widths. "master" is the framebuffer writer's
// view (it masters the Avalon bus); "slave" is the source/memory side.
interface video_fb_writer_if #(
  parameter int RGB_SIZE  = 12,
  parameter int AVN_AW    = 20,
  parameter int AVN_DW    = 16,
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480
);
  localparam int HC_W = $clog2(H_DISPLAY);
  localparam int VC_W = $clog2(V_DISPLAY);

  logic                  src_vld;
  logic                  src_rdy;
  logic [RGB_SIZE-1:0]   src_rgb;
  logic [HC_W-1:0]       src_hc;
  logic [VC_W-1:0]       src_vc;

  logic                  avn_write;
  logic [AVN_AW-1:0]     avn_address;
  logic [AVN_DW-1:0]     avn_writedata;
  logic [AVN_DW/8-1:0]   avn_byteenable;
  logic                  avn_waitrequest;

  modport master (
    input  src_vld, src_rgb, src_hc, src_vc, avn_waitrequest,
    output src_rdy, avn_write, avn_address, avn_writedata, avn_byteenable
  );

  modport slave (
    output src_vld, src_rgb, src_hc, src_vc, avn_waitrequest,
    input  src_rdy, avn_write, avn_address, avn_writedata, avn_byteenable
  );
endinterface

// File: rtl/video_fb_writer.sv
// Framebuffer writer: turns a coordinate-tagged pixel stream into Avalon-MM
// word writes, optionally packing two pixels per word, with two-page
// (front/back) buffering swapped at frame boundaries.
module video_fb_writer #(
  parameter int RGB_SIZE    = 12,
  parameter int AVN_AW      = 20,
  parameter int AVN_DW      = 16,
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int PACK        = 1,
  parameter int DOUBLE_BUF  = 1,
  parameter int PAGE_OFFSET = 2**19
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  video_fb_writer_if.master  bus,
  input  logic               swap_req,
  output logic               front_page,
  output logic               frame_done
);

  localparam int HC_W   = $clog2(H_DISPLAY);
  localparam int VC_W   = $clog2(V_DISPLAY);
  localparam int HALF_W = AVN_DW / 2;
  localparam int BE_W   = AVN_DW / 8;
  localparam logic [BE_W-1:0] BE_ALL = '1;
  localparam logic [BE_W-1:0] BE_LO  = BE_ALL >> (BE_W / 2);
  localparam logic [BE_W-1:0] BE_HI  = BE_ALL << (BE_W / 2);

  typedef enum logic {EMPTY, HALF} pack_state_t;

  pack_state_t         state, state_nxt;

  logic                write_q;
  logic [AVN_AW-1:0]   addr_q;
  logic [AVN_DW-1:0]   data_q;
  logic [BE_W-1:0]     be_q;
  logic                last_q;

  logic [HALF_W-1:0]   held_lo;
  logic [HC_W-1:0]     held_hc;
  logic [VC_W-1:0]     held_vc;
  logic [AVN_AW-1:0]   held_addr;

  logic                write_page;
  logic                swap_pending;
  logic                frame_done_q;

  logic                out_free;
  logic                in_range;
  logic                is_last;
  logic                is_edge;
  logic                consecutive;
  logic                flush;
  logic                accept;
  logic [31:0]         pix_index;
  logic [AVN_AW-1:0]   pix_addr;
  logic [HALF_W-1:0]   new_half;

  logic                issue;
  logic [AVN_AW-1:0]   issue_addr;
  logic [AVN_DW-1:0]   issue_data;
  logic [BE_W-1:0]     issue_be;
  logic                issue_last;
  logic                hold;

  assign bus.avn_write      = write_q;
  assign bus.avn_address    = addr_q;
  assign bus.avn_writedata  = data_q;
  assign bus.avn_byteenable = be_q;
  assign frame_done         = frame_done_q;
  assign front_page         = (DOUBLE_BUF == 1) ? ~write_page : 1'b0;

  // The output register can take a new word when empty or when its current
  // word is being accepted this cycle. A flush steals one free slot to drain
  // the held half before the non-adjacent pixel is taken.
  assign out_free    = ~write_q | ~bus.avn_waitrequest;
  assign in_range    = (32'(bus.src_hc) < H_DISPLAY) && (32'(bus.src_vc) < V_DISPLAY);
  assign is_last     = (32'(bus.src_hc) == H_DISPLAY - 1) && (32'(bus.src_vc) == V_DISPLAY - 1);
  assign is_edge     = (32'(bus.src_hc) == H_DISPLAY - 1);
  assign consecutive = (held_hc + HC_W'(1) == bus.src_hc) && (held_vc == bus.src_vc);
  assign flush       = (PACK == 2) && (state == HALF) && out_free && bus.src_vld &&
                       in_range && !consecutive;
  assign bus.src_rdy = out_free & ~flush;
  assign accept      = bus.src_vld & bus.src_rdy;
  assign pix_index   = 32'(bus.src_vc) * 32'(H_DISPLAY) + 32'(bus.src_hc);
  assign pix_addr    = AVN_AW'(pix_index / 32'(PACK)) +
                       (write_page ? AVN_AW'(PAGE_OFFSET) : AVN_AW'(0));
  assign new_half    = HALF_W'(bus.src_rgb);

  // Packer state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= EMPTY;
    else            state <= state_nxt;
  end

  // Decide what word (if any) to issue this cycle and where the packer goes.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_addr = pix_addr;
    issue_data = '0;
    issue_be   = '0;
    issue_last = 1'b0;
    hold       = 1'b0;
    if (flush) begin
      issue      = 1'b1;
      issue_addr = held_addr;
      issue_data = {HALF_W'(0), held_lo};
      issue_be   = BE_LO;
      state_nxt  = EMPTY;
    end else if (accept && in_range) begin
      if (PACK == 1) begin
        issue      = 1'b1;
        issue_data = AVN_DW'(bus.src_rgb);
        issue_be   = BE_ALL;
        issue_last = is_last;
      end else if (state == HALF) begin
        issue      = 1'b1;
        issue_addr = held_addr;
        issue_data = {new_half, held_lo};
        issue_be   = BE_ALL;
        issue_last = is_last;
        state_nxt  = EMPTY;
      end else if (!bus.src_hc[0] && !is_edge) begin
        hold      = 1'b1;
        state_nxt = HALF;
      end else if (!bus.src_hc[0]) begin
        issue      = 1'b1;
        issue_data = {HALF_W'(0), new_half};
        issue_be   = BE_LO;
        issue_last = is_last;
      end else begin
        issue      = 1'b1;
        issue_data = {new_half, HALF_W'(0)};
        issue_be   = BE_HI;
        issue_last = is_last;
      end
    end
  end

  // Single output stage: only reloads when the bus is not stalling it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      last_q  <= 1'b0;
    end else if (out_free) begin
      write_q <= issue;
      if (issue) begin
        addr_q <= issue_addr;
        data_q <= issue_data;
        be_q   <= issue_be;
        last_q <= issue_last;
      end
    end
  end

  // Held low-half pixel, with the address captured at acceptance so a later
  // page swap cannot move it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      held_lo   <= '0;
      held_hc   <= '0;
      held_vc   <= '0;
      held_addr <= '0;
    end else if (hold) begin
      held_lo   <= new_half;
      held_hc   <= bus.src_hc;
      held_vc   <= bus.src_vc;
      held_addr <= pix_addr;
    end
  end

  // End-of-frame pulse and page swap bookkeeping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_done_q <= 1'b0;
      write_page   <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      frame_done_q <= write_q & ~bus.avn_waitrequest & last_q;
      if (frame_done_q && (swap_pending || swap_req)) begin
        write_page   <= (DOUBLE_BUF == 1) ? ~write_page : 1'b0;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_fb_writer.sv
// Directed bench: d1 is the default single-pixel-per-word writer, d2 packs
// two 8-bit pixels per 16-bit word. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_video_fb_writer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic swap1 = 1'b0;
  logic swap2 = 1'b0;
  logic fp1, fp2, fd1, fd2;
  int   checks = 0;
  int   passes = 0;

  video_fb_writer_if #(.RGB_SIZE(12)) if1 ();
  video_fb_writer_if #(.RGB_SIZE(8))  if2 ();

  video_fb_writer #(.RGB_SIZE(12), .PACK(1)) d1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(if1.master),
    .swap_req(swap1), .front_page(fp1), .frame_done(fd1)
  );

  video_fb_writer #(.RGB_SIZE(8), .PACK(2)) d2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(if2.master),
    .swap_req(swap2), .front_page(fp2), .frame_done(fd2)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic drive1(input logic v, input int hc, input int vc, input int rgb);
    if1.src_vld = v;
    if1.src_hc  = 10'(hc);
    if1.src_vc  = 9'(vc);
    if1.src_rgb = 12'(rgb);
  endtask

  task automatic drive2(input logic v, input int hc, input int vc, input int rgb);
    if2.src_vld = v;
    if2.src_hc  = 10'(hc);
    if2.src_vc  = 9'(vc);
    if2.src_rgb = 8'(rgb);
  endtask

  task automatic test_reset();
    drive1(0, 0, 0, 0);
    drive2(0, 0, 0, 0);
    if1.avn_waitrequest = 1'b0;
    if2.avn_waitrequest = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (if1.avn_write !== 1'b0) $display("[TB] FAIL reset_write: got %b want 0", if1.avn_write); else passes++;
    checks++; if (if1.avn_address !== 20'd0) $display("[TB] FAIL reset_addr: got %h want 0", if1.avn_address); else passes++;
    checks++; if (if1.avn_writedata !== 16'd0) $display("[TB] FAIL reset_data: got %h want 0", if1.avn_writedata); else passes++;
    checks++; if (if1.avn_byteenable !== 2'b00) $display("[TB] FAIL reset_be: got %b want 00", if1.avn_byteenable); else passes++;
    checks++; if (fd1 !== 1'b0) $display("[TB] FAIL reset_frame_done: got %b want 0", fd1); else passes++;
    checks++; if (fp1 !== 1'b1) $display("[TB] FAIL reset_front_page: got %b want 1", fp1); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (if1.src_rdy !== 1'b1) $display("[TB] FAIL reset_rdy1: got %b want 1", if1.src_rdy); else passes++;
    checks++; if (if2.src_rdy !== 1'b1) $display("[TB] FAIL reset_rdy2: got %b want 1", if2.src_rdy); else passes++;
  endtask

  task automatic test_pack1_basic();
    drive1(1, 3, 2, 'hABC);
    @(negedge clk);
    drive1(0, 0, 0, 0);
    checks++; if (if1.avn_write !== 1'b1) $display("[TB] FAIL p1_write: got %b want 1", if1.avn_write); else passes++;
    checks++; if (if1.avn_address !== 20'd1283) $display("[TB] FAIL p1_addr: got %0d want 1283", if1.avn_address); else passes++;
    checks++; if (if1.avn_writedata !== 16'h0ABC) $display("[TB] FAIL p1_data: got %h want 0abc", if1.avn_writedata); else passes++;
    checks++; if (if1.avn_byteenable !== 2'b11) $display("[TB] FAIL p1_be: got %b want 11", if1.avn_byteenable); else passes++;
    @(negedge clk);
    checks++; if (if1.avn_write !== 1'b0) $display("[TB] FAIL p1_idle: got %b want 0", if1.avn_write); else passes++;
  endtask

  task automatic test_pack2_pair();
    drive2(1, 10, 0, 'h11);
    @(negedge clk);
    checks++; if (if2.avn_write !== 1'b0) $display("[TB] FAIL p2_hold: got %b want 0", if2.avn_write); else passes++;
    drive2(1, 11, 0, 'h22);
    @(negedge clk);
    drive2(0, 0, 0, 0);
    checks++; if (if2.avn_write !== 1'b1) $display("[TB] FAIL p2_write: got %b want 1", if2.avn_write); else passes++;
    checks++; if (if2.avn_address !== 20'd5) $display("[TB] FAIL p2_addr: got %0d want 5", if2.avn_address); else passes++;
    checks++; if (if2.avn_writedata !== 16'h2211) $display("[TB] FAIL p2_data: got %h want 2211", if2.avn_writedata); else passes++;
    checks++; if (if2.avn_byteenable !== 2'b11) $display("[TB] FAIL p2_be: got %b want 11", if2.avn_byteenable); else passes++;
    @(negedge clk);
  endtask

  task automatic test_pack2_flush();
    drive2(1, 10, 0, 'h33);
    @(negedge clk);
    drive2(1, 20, 0, 'h44);
    #1;
    checks++; if (if2.src_rdy !== 1'b0) $display("[TB] FAIL flush_rdy_low: got %b want 0", if2.src_rdy); else passes++;
    @(negedge clk);
    checks++; if (if2.avn_write !== 1'b1) $display("[TB] FAIL flush_write: got %b want 1", if2.avn_write); else passes++;
    checks++; if (if2.avn_address !== 20'd5) $display("[TB] FAIL flush_addr: got %0d want 5", if2.avn_address); else passes++;
    checks++; if (if2.avn_writedata !== 16'h0033) $display("[TB] FAIL flush_data: got %h want 0033", if2.avn_writedata); else passes++;
    checks++; if (if2.avn_byteenable !== 2'b01) $display("[TB] FAIL flush_be: got %b want 01", if2.avn_byteenable); else passes++;
    checks++; if (if2.src_rdy !== 1'b1) $display("[TB] FAIL flush_rdy_back: got %b want 1", if2.src_rdy); else passes++;
    @(negedge clk);
    checks++; if (if2.avn_write !== 1'b0) $display("[TB] FAIL flush_rehold: got %b want 0", if2.avn_write); else passes++;
    drive2(1, 21, 0, 'h55);
    @(negedge clk);
    drive2(0, 0, 0, 0);
    checks++; if (if2.avn_address !== 20'd10) $display("[TB] FAIL flush_pair_addr: got %0d want 10", if2.avn_address); else passes++;
    checks++; if (if2.avn_writedata !== 16'h5544) $display("[TB] FAIL flush_pair_data: got %h want 5544", if2.avn_writedata); else passes++;
    @(negedge clk);
  endtask

  task automatic test_waitrequest();
    drive1(1, 5, 0, 'h123);
    @(negedge clk);
    if1.avn_waitrequest = 1'b1;
    drive1(1, 6, 0, 'h456);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if1.src_rdy !== 1'b0) $display("[TB] FAIL wait_rdy[%0d]: got %b want 0", i, if1.src_rdy); else passes++;
      @(negedge clk);
      checks++; if (if1.avn_write !== 1'b1) $display("[TB] FAIL wait_write[%0d]: got %b want 1", i, if1.avn_write); else passes++;
      checks++; if (if1.avn_address !== 20'd5) $display("[TB] FAIL wait_addr[%0d]: got %0d want 5", i, if1.avn_address); else passes++;
      checks++; if (if1.avn_writedata !== 16'h0123) $display("[TB] FAIL wait_data[%0d]: got %h want 0123", i, if1.avn_writedata); else passes++;
    end
    if1.avn_waitrequest = 1'b0;
    #1;
    checks++; if (if1.src_rdy !== 1'b1) $display("[TB] FAIL wait_release_rdy: got %b want 1", if1.src_rdy); else passes++;
    @(negedge clk);
    drive1(0, 0, 0, 0);
    checks++; if (if1.avn_address !== 20'd6) $display("[TB] FAIL wait_next_addr: got %0d want 6", if1.avn_address); else passes++;
    checks++; if (if1.avn_writedata !== 16'h0456) $display("[TB] FAIL wait_next_data: got %h want 0456", if1.avn_writedata); else passes++;
    @(negedge clk);
    checks++; if (if1.avn_write !== 1'b0) $display("[TB] FAIL wait_drain: got %b want 0", if1.avn_write); else passes++;
  endtask

  task automatic test_swap_frame();
    swap1 = 1'b1;
    @(negedge clk);
    swap1 = 1'b0;
    checks++; if (fp1 !== 1'b1) $display("[TB] FAIL swap_early_fp: got %b want 1", fp1); else passes++;
    drive1(1, 639, 479, 'hFFF);
    @(negedge clk);
    drive1(0, 0, 0, 0);
    checks++; if (if1.avn_address !== 20'd307199) $display("[TB] FAIL last_addr: got %0d want 307199", if1.avn_address); else passes++;
    checks++; if (fd1 !== 1'b0) $display("[TB] FAIL done_early: got %b want 0", fd1); else passes++;
    @(negedge clk);
    checks++; if (fd1 !== 1'b1) $display("[TB] FAIL done_pulse: got %b want 1", fd1); else passes++;
    checks++; if (fp1 !== 1'b1) $display("[TB] FAIL swap_fp_before: got %b want 1", fp1); else passes++;
    @(negedge clk);
    checks++; if (fd1 !== 1'b0) $display("[TB] FAIL done_single: got %b want 0", fd1); else passes++;
    checks++; if (fp1 !== 1'b0) $display("[TB] FAIL swap_fp_after: got %b want 0", fp1); else passes++;
    drive1(1, 0, 0, 'h001);
    @(negedge clk);
    drive1(0, 0, 0, 0);
    checks++; if (if1.avn_write !== 1'b1) $display("[TB] FAIL page1_write: got %b want 1", if1.avn_write); else passes++;
    checks++; if (if1.avn_address !== 20'd524288) $display("[TB] FAIL page1_addr: got %0d want 524288", if1.avn_address); else passes++;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    drive2(1, 30, 0, 'h66);
    drive1(1, 700, 0, 'h777);
    @(negedge clk);
    drive1(0, 0, 0, 0);
    checks++; if (if1.avn_write !== 1'b0) $display("[TB] FAIL oor1_write: got %b want 0", if1.avn_write); else passes++;
    drive2(1, 700, 0, 'h77);
    #1;
    checks++; if (if2.src_rdy !== 1'b1) $display("[TB] FAIL oor2_rdy: got %b want 1", if2.src_rdy); else passes++;
    @(negedge clk);
    checks++; if (if2.avn_write !== 1'b0) $display("[TB] FAIL oor2_write: got %b want 0", if2.avn_write); else passes++;
    drive2(1, 31, 0, 'h88);
    @(negedge clk);
    drive2(0, 0, 0, 0);
    checks++; if (if2.avn_address !== 20'd15) $display("[TB] FAIL oor2_pair_addr: got %0d want 15", if2.avn_address); else passes++;
    checks++; if (if2.avn_writedata !== 16'h8866) $display("[TB] FAIL oor2_pair_data: got %h want 8866", if2.avn_writedata); else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_midtransfer();
    if1.avn_waitrequest = 1'b1;
    drive1(1, 7, 0, 'h321);
    drive2(1, 40, 0, 'h99);
    @(negedge clk);
    drive1(0, 0, 0, 0);
    drive2(0, 0, 0, 0);
    checks++; if (if1.avn_write !== 1'b1) $display("[TB] FAIL mid_pending: got %b want 1", if1.avn_write); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if1.avn_write !== 1'b0) $display("[TB] FAIL mid_async_clear: got %b want 0", if1.avn_write); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    if1.avn_waitrequest = 1'b0;
    @(negedge clk);
    checks++; if (if1.src_rdy !== 1'b1) $display("[TB] FAIL mid_rdy1: got %b want 1", if1.src_rdy); else passes++;
    checks++; if (if2.src_rdy !== 1'b1) $display("[TB] FAIL mid_rdy2: got %b want 1", if2.src_rdy); else passes++;
    drive2(1, 41, 0, 'hAA);
    @(negedge clk);
    drive2(0, 0, 0, 0);
    checks++; if (if2.avn_address !== 20'd20) $display("[TB] FAIL mid_odd_addr: got %0d want 20", if2.avn_address); else passes++;
    checks++; if (if2.avn_writedata !== 16'hAA00) $display("[TB] FAIL mid_odd_data: got %h want aa00", if2.avn_writedata); else passes++;
    checks++; if (if2.avn_byteenable !== 2'b10) $display("[TB] FAIL mid_odd_be: got %b want 10", if2.avn_byteenable); else passes++;
    @(negedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_pack1_basic();
    test_pack2_pair();
    test_pack2_flush();
    test_waitrequest();
    test_swap_frame();
    test_out_of_range();
    test_reset_midtransfer();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
